// File: rtl/t80_reg_banked.sv
// Banked register-pair file for the T80 datapath: three combinational read ports,
// split high/low writes, port-A pair increment/decrement and a bank-advance command.
module t80_reg_banked #(
    parameter int unsigned DW     = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned BANKS  = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned BW    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic          Clk,
    input  logic          RESET_n,
    input  logic          CEN,
    input  logic          WEH,
    input  logic          WEL,
    input  logic          IncA,
    input  logic          DecA,
    input  logic          Swap,
    input  logic [AW-1:0] AddrA,
    input  logic [AW-1:0] AddrB,
    input  logic [AW-1:0] AddrC,
    input  logic [DW-1:0] DIH,
    input  logic [DW-1:0] DIL,
    output logic [DW-1:0] DOAH,
    output logic [DW-1:0] DOAL,
    output logic [DW-1:0] DOBH,
    output logic [DW-1:0] DOBL,
    output logic [DW-1:0] DOCH,
    output logic [DW-1:0] DOCL,
    output logic [BW-1:0] ActBank
);

    logic [DW-1:0]   reg_h_q [BANKS][DEPTH];
    logic [DW-1:0]   reg_l_q [BANKS][DEPTH];
    logic [BW-1:0]   act_bank_q;
    logic [BW-1:0]   bank_nxt;
    logic [2*DW-1:0] pair_cur;
    logic [2*DW-1:0] pair_nxt;
    logic            incdec_en;

    logic [AW-1:0]   rd_addr [3];
    logic [DW-1:0]   rd_h    [3];
    logic [DW-1:0]   rd_l    [3];

    // Any half-write wins over inc/dec; Inc and Dec together cancel.
    assign incdec_en = ~WEH & ~WEL & (IncA ^ DecA);
    assign pair_cur  = {reg_h_q[act_bank_q][AddrA], reg_l_q[act_bank_q][AddrA]};
    assign pair_nxt  = IncA ? pair_cur + (2*DW)'(1) : pair_cur - (2*DW)'(1);

    // BANKS is a power of two, so the natural BW-bit wrap gives the modulo.
    assign bank_nxt  = (BANKS > 1) ? act_bank_q + BW'(1) : '0;

    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    reg_h_q[b][d] <= '0;
                    reg_l_q[b][d] <= '0;
                end
            end
            act_bank_q <= '0;
        end else if (CEN) begin
            if (WEH) begin
                reg_h_q[act_bank_q][AddrA] <= DIH;
            end
            if (WEL) begin
                reg_l_q[act_bank_q][AddrA] <= DIL;
            end
            if (incdec_en) begin
                reg_h_q[act_bank_q][AddrA] <= pair_nxt[2*DW-1:DW];
                reg_l_q[act_bank_q][AddrA] <= pair_nxt[DW-1:0];
            end
            if (Swap) begin
                act_bank_q <= bank_nxt;
            end
        end
    end

    assign rd_addr[0] = AddrA;
    assign rd_addr[1] = AddrB;
    assign rd_addr[2] = AddrC;

    // Forwarding covers only the half being written; inc/dec results are never forwarded.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_h[p] = reg_h_q[act_bank_q][rd_addr[p]];
            rd_l[p] = reg_l_q[act_bank_q][rd_addr[p]];
            if ((BYPASS != 0) && CEN && (rd_addr[p] == AddrA)) begin
                if (WEH) begin
                    rd_h[p] = DIH;
                end
                if (WEL) begin
                    rd_l[p] = DIL;
                end
            end
        end
    end

    assign DOAH    = rd_h[0];
    assign DOAL    = rd_l[0];
    assign DOBH    = rd_h[1];
    assign DOBL    = rd_l[1];
    assign DOCH    = rd_h[2];
    assign DOCL    = rd_l[2];
    assign ActBank = act_bank_q;

endmodule

// File: tb/tb_t80_reg_banked.sv
// Directed bench for t80_reg_banked: a vector table for writes, inc/dec, CEN gating and
// bank swaps, plus hand sequences for bypass and asynchronous reset.
module tb_t80_reg_banked;

    logic       Clk;
    logic       RESET_n;
    logic       CEN, WEH, WEL, IncA, DecA, Swap;
    logic [2:0] AddrA, AddrB, AddrC;
    logic [7:0] DIH, DIL;

    logic [7:0] doah, doal, dobh, dobl, doch, docl;
    logic [0:0] act_bank;
    logic [7:0] n_doah, n_doal, n_dobh, n_dobl, n_doch, n_docl;
    logic [0:0] n_act_bank;

    int n_pass;
    int n_total;

    typedef struct {
        logic       cen, weh, wel, inc, dec, swap;
        logic [2:0] addra;
        logic [7:0] dih, dil;
        logic [2:0] chk;
        logic [7:0] eh, el;
        logic       eb;
    } vec_t;

    vec_t vq[$];

    t80_reg_banked #(.DW(8), .DEPTH(8), .BANKS(2), .BYPASS(1)) dut (
        .Clk     (Clk),
        .RESET_n (RESET_n),
        .CEN     (CEN),
        .WEH     (WEH),
        .WEL     (WEL),
        .IncA    (IncA),
        .DecA    (DecA),
        .Swap    (Swap),
        .AddrA   (AddrA),
        .AddrB   (AddrB),
        .AddrC   (AddrC),
        .DIH     (DIH),
        .DIL     (DIL),
        .DOAH    (doah),
        .DOAL    (doal),
        .DOBH    (dobh),
        .DOBL    (dobl),
        .DOCH    (doch),
        .DOCL    (docl),
        .ActBank (act_bank)
    );

    t80_reg_banked #(.DW(8), .DEPTH(8), .BANKS(2), .BYPASS(0)) dut_nb (
        .Clk     (Clk),
        .RESET_n (RESET_n),
        .CEN     (CEN),
        .WEH     (WEH),
        .WEL     (WEL),
        .IncA    (IncA),
        .DecA    (DecA),
        .Swap    (Swap),
        .AddrA   (AddrA),
        .AddrB   (AddrB),
        .AddrC   (AddrC),
        .DIH     (DIH),
        .DIL     (DIL),
        .DOAH    (n_doah),
        .DOAL    (n_doal),
        .DOBH    (n_dobh),
        .DOBL    (n_dobl),
        .DOCH    (n_doch),
        .DOCL    (n_docl),
        .ActBank (n_act_bank)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic ctrl_idle();
        CEN  = 1'b1;
        WEH  = 1'b0;
        WEL  = 1'b0;
        IncA = 1'b0;
        DecA = 1'b0;
        Swap = 1'b0;
    endtask

    task automatic add(input logic cen, input logic weh, input logic wel, input logic inc,
                       input logic dec, input logic swap, input logic [2:0] addra,
                       input logic [7:0] dih, input logic [7:0] dil, input logic [2:0] chka,
                       input logic [7:0] eh, input logic [7:0] el, input logic eb);
        vec_t v;
        v.cen = cen; v.weh = weh; v.wel = wel; v.inc = inc; v.dec = dec; v.swap = swap;
        v.addra = addra; v.dih = dih; v.dil = dil; v.chk = chka;
        v.eh = eh; v.el = el; v.eb = eb;
        vq.push_back(v);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        RESET_n = 1'b0;
        ctrl_idle();
        AddrA = 3'd0; AddrB = 3'd0; AddrC = 3'd0;
        DIH = 8'h00; DIL = 8'h00;

        //  cen weh wel inc dec swp addrA dih    dil    chk   expH   expL   bank
        add(1, 1, 0, 0, 0, 0, 3'd2, 8'hAB, 8'h00, 3'd2, 8'hAB, 8'h00, 0);
        add(1, 0, 1, 0, 0, 0, 3'd2, 8'h00, 8'hCD, 3'd2, 8'hAB, 8'hCD, 0);
        add(1, 1, 0, 0, 0, 0, 3'd2, 8'hEE, 8'h99, 3'd2, 8'hEE, 8'hCD, 0);
        add(1, 1, 1, 0, 0, 0, 3'd5, 8'h00, 8'hFF, 3'd5, 8'h00, 8'hFF, 0);
        add(1, 0, 0, 1, 0, 0, 3'd5, 8'h00, 8'h00, 3'd5, 8'h01, 8'h00, 0);
        add(1, 1, 1, 0, 0, 0, 3'd5, 8'hFF, 8'hFF, 3'd5, 8'hFF, 8'hFF, 0);
        add(1, 0, 0, 1, 0, 0, 3'd5, 8'h00, 8'h00, 3'd5, 8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 1, 0, 3'd5, 8'h00, 8'h00, 3'd5, 8'hFF, 8'hFF, 0);
        add(1, 0, 0, 1, 1, 0, 3'd5, 8'h00, 8'h00, 3'd5, 8'hFF, 8'hFF, 0);
        add(1, 0, 1, 1, 0, 0, 3'd5, 8'h00, 8'h11, 3'd5, 8'hFF, 8'h11, 0);
        add(1, 0, 0, 0, 1, 0, 3'd5, 8'h00, 8'h00, 3'd5, 8'hFF, 8'h10, 0);
        add(1, 1, 1, 0, 0, 0, 3'd6, 8'h01, 8'h00, 3'd6, 8'h01, 8'h00, 0);
        add(1, 0, 0, 0, 1, 0, 3'd6, 8'h00, 8'h00, 3'd6, 8'h00, 8'hFF, 0);
        for (int k = 0; k < 4; k++) begin
            add(0, 1, 1, 1, 0, 1, 3'd5, 8'h77, 8'h77, 3'd5, 8'hFF, 8'h10, 0);
        end
        add(1, 1, 1, 0, 0, 0, 3'd1, 8'h11, 8'h11, 3'd1, 8'h11, 8'h11, 0);
        add(1, 1, 1, 0, 0, 1, 3'd1, 8'h22, 8'h22, 3'd1, 8'h00, 8'h00, 1);
        add(1, 1, 1, 0, 0, 0, 3'd1, 8'h33, 8'h44, 3'd1, 8'h33, 8'h44, 1);
        add(1, 0, 0, 0, 0, 1, 3'd1, 8'h00, 8'h00, 3'd1, 8'h22, 8'h22, 0);
        add(1, 0, 0, 0, 0, 1, 3'd1, 8'h00, 8'h00, 3'd1, 8'h33, 8'h44, 1);
        add(1, 0, 0, 0, 0, 1, 3'd2, 8'h00, 8'h00, 3'd2, 8'hEE, 8'hCD, 0);

        // Reset state, sampled while reset is held
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_doah", 32'(doah), 32'h00);
        chk("rst_doal", 32'(doal), 32'h00);
        chk("rst_bank", 32'(act_bank), 32'h0);
        @(negedge Clk);
        RESET_n = 1'b1;
        @(posedge Clk);
        #1;

        foreach (vq[i]) begin
            CEN = vq[i].cen; WEH = vq[i].weh; WEL = vq[i].wel;
            IncA = vq[i].inc; DecA = vq[i].dec; Swap = vq[i].swap;
            AddrA = vq[i].addra; DIH = vq[i].dih; DIL = vq[i].dil;
            AddrB = vq[i].chk;
            @(posedge Clk);
            #1;
            ctrl_idle();
            #1;
            chk($sformatf("vec%0d_bh", i), 32'(dobh), 32'(vq[i].eh));
            chk($sformatf("vec%0d_bl", i), 32'(dobl), 32'(vq[i].el));
            chk($sformatf("vec%0d_bank", i), 32'(act_bank), 32'(vq[i].eb));
            chk($sformatf("vec%0d_nb_bh", i), 32'(n_dobh), 32'(vq[i].eh));
            chk($sformatf("vec%0d_nb_bl", i), 32'(n_dobl), 32'(vq[i].el));
        end

        // Bypass: seed pair 4 of bank 0 with 9C3E
        WEH = 1'b1; WEL = 1'b1; AddrA = 3'd4; DIH = 8'h9C; DIL = 8'h3E;
        @(posedge Clk);
        #1;
        ctrl_idle();
        AddrA = 3'd4; AddrC = 3'd4; WEL = 1'b1; DIL = 8'h5A;
        #1;
        chk("byp_docl", 32'(docl), 32'h5A);
        chk("byp_doch_stored", 32'(doch), 32'h9C);
        chk("nobyp_docl_old", 32'(n_docl), 32'h3E);
        chk("nobyp_doch", 32'(n_doch), 32'h9C);
        @(posedge Clk);
        #1;
        WEL = 1'b0;
        #1;
        chk("nobyp_docl_next", 32'(n_docl), 32'h5A);
        WEH = 1'b1; DIH = 8'hC3;
        #1;
        chk("byp_doch", 32'(doch), 32'hC3);
        chk("byp_docl_stored", 32'(docl), 32'h5A);
        chk("nobyp_doch_old", 32'(n_doch), 32'h9C);
        CEN = 1'b0;
        #1;
        chk("byp_cen0", 32'(doch), 32'h9C);
        CEN = 1'b1; AddrC = 3'd3;
        #1;
        chk("byp_addr_miss", 32'(doch), 32'h00);
        WEH = 1'b0;

        // Asynchronous reset between edges, from bank 1 with pair 3 written
        @(posedge Clk);
        #1;
        Swap = 1'b1;
        @(posedge Clk);
        #1;
        Swap = 1'b0;
        WEH = 1'b1; WEL = 1'b1; AddrA = 3'd3; DIH = 8'h12; DIL = 8'h34;
        @(posedge Clk);
        #1;
        ctrl_idle();
        #1;
        chk("pre_rst_doah", 32'(doah), 32'h12);
        chk("pre_rst_doal", 32'(doal), 32'h34);
        chk("pre_rst_bank", 32'(act_bank), 32'h1);
        #1;
        RESET_n = 1'b0;
        #1;
        chk("async_rst_doah", 32'(doah), 32'h00);
        chk("async_rst_doal", 32'(doal), 32'h00);
        chk("async_rst_bank", 32'(act_bank), 32'h0);
        #1;
        RESET_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("post_rst_doah", 32'(doah), 32'h00);
        chk("post_rst_doal", 32'(doal), 32'h00);
        chk("post_rst_bank", 32'(act_bank), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
